eth_mdio_ctrl: RTL

ETH_MDIO_CTRL -- requirements
Module: eth_mdio_ctrl

---
 rtl/eth_mdio_pkg.sv | 65 ++++++
 rtl/eth_mdio_clkgen.sv | 51 +++++
 rtl/eth_mdio_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/eth_mdio_pkg.sv
// Shared MDIO management-frame definitions: FSM states, frame constants and helpers.
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StStop,
        StAddr,
        StTa,
        StData,
        StGap
    } mdio_state_e;

    localparam int unsigned MDIO_PRE_BITS   = 32;
    localparam logic [1:0]  MDIO_ST         = 2'b01;
    localparam logic [1:0]  MDIO_OP_WR      = 2'b01;
    localparam logic [1:0]  MDIO_OP_RD      = 2'b10;
    localparam logic [1:0]  MDIO_TA_WR      = 2'b10;
    // Read turnaround is released; the internal value just idles high.
    localparam logic [1:0]  MDIO_TA_RD      = 2'b11;
    // ST+OP (4) + PHY/REG (10) + TA (2) + DATA (16) + GAP (1)
    localparam int unsigned MDIO_BODY_BITS  = 33;
    localparam int unsigned MDIO_FRAME_BITS = MDIO_PRE_BITS + MDIO_BODY_BITS;

    // Index of the final bit of each frame field.
    function automatic logic [4:0] state_last_bit(mdio_state_e s);
        logic [4:0] last;
        case (s)
            StPre:   last = 5'(MDIO_PRE_BITS - 1);
            StStop:  last = 5'd3;
            StAddr:  last = 5'd9;
            StTa:    last = 5'd1;
            StData:  last = 5'd15;
            default: last = 5'd0;
        endcase
        return last;
    endfunction

    function automatic mdio_state_e state_next(mdio_state_e s);
        mdio_state_e nx;
        case (s)
            StPre:   nx = StStop;
            StStop:  nx = StAddr;
            StAddr:  nx = StTa;
            StTa:    nx = StData;
            StData:  nx = StGap;
            default: nx = StIdle;
        endcase
        return nx;
    endfunction

    // Serial bit values of the frame after the preamble, first bit in the MSB.
    function automatic logic [MDIO_BODY_BITS-1:0] frame_body(logic write, logic [4:0] phy,
                                                             logic [4:0] regad,
                                                             logic [15:0] wdata);
        return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phy, regad,
                (write ? MDIO_TA_WR : MDIO_TA_RD), (write ? wdata : 16'hFFFF), 1'b1};
    endfunction

    // Output-enable per body bit: reads release the line from the first TA bit onward.
    function automatic logic [MDIO_BODY_BITS-1:0] frame_oe(logic write);
        return {14'h3FFF, (write ? 18'h3FFFF : 18'h00000), 1'b0};
    endfunction

endpackage

// File: rtl/eth_mdio_clkgen.sv
// Bit-phase counter and MDC generator; provides edge strobes for the frame sequencer.
module eth_mdio_clkgen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    input  logic mdc_en,
    output logic mdc,
    output logic fall,
    output logic rise,
    output logic bit_end
);

    localparam int unsigned PHASES = 2 * CLK_DIV;
    localparam int unsigned PW     = $clog2(PHASES);

    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_PRE  = PW'(PHASES - 2);
    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;

    // Next phase: wraps every bit, parks at 0 while idle or on a new frame.
    always_comb begin
        phase_nx = '0;
        if (!restart && run && (phase != PH_LAST)) begin
            phase_nx = phase + 1'b1;
        end
    end

    // Phase register and registered MDC (high for the second half of each bit).
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            mdc   <= 1'b0;
        end else begin
            phase <= phase_nx;
            mdc   <= run && !restart && mdc_en && (phase_nx >= PH_HIGH);
        end
    end

    // Edge strobes: each marks the clock edge at which the event takes effect.
    assign rise    = run && (phase == PH_RISE);
    assign fall    = run && (phase == PH_LAST);
    assign bit_end = run && (phase == PH_PRE);

endmodule

// File: rtl/eth_mdio_ctrl.sv
// MDIO (clause 22) management controller: one read or write frame per accepted request.
module eth_mdio_ctrl
    import eth_mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned PREAMBLE_EN = 1
) (
    input  logic        msoc_clk,
    input  logic        rst_int,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        phy_mdc,
    input  logic        phy_mdio_i,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oen
);

    localparam int unsigned FB = MDIO_FRAME_BITS;

    if ((CLK_DIV < 2) || (CLK_DIV > 255)) begin : gen_bad_clk_div
        $error("eth_mdio_ctrl: CLK_DIV must be within 2..255");
    end

    mdio_state_e   state;
    logic [4:0]    bit_cnt;
    logic          is_write;
    logic          ta_err;
    logic [15:0]   rd_sr;
    logic [FB-1:0] tx_sr;
    logic [FB-1:0] oe_sr;
    logic [FB-1:0] frame_tx;
    logic [FB-1:0] frame_en;
    logic          accept;
    logic          fall;
    logic          rise;
    logic          bit_end;

    assign req_ready = (state == StIdle) && !rst_int;
    assign busy      = (state != StIdle);
    assign accept    = req_valid && req_ready;

    // Whole frame as pin values, first bit in the MSB; without preamble the body is left-aligned.
    always_comb begin
        if (PREAMBLE_EN != 0) begin
            frame_tx = {{MDIO_PRE_BITS{1'b1}}, frame_body(req_write, req_phy, req_reg, req_wdata)};
            frame_en = {{MDIO_PRE_BITS{1'b1}}, frame_oe(req_write)};
        end else begin
            frame_tx = {frame_body(req_write, req_phy, req_reg, req_wdata), {MDIO_PRE_BITS{1'b1}}};
            frame_en = {frame_oe(req_write), {MDIO_PRE_BITS{1'b0}}};
        end
    end

    eth_mdio_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk    (msoc_clk),
        .rst    (rst_int),
        .restart(accept),
        .run    (busy),
        .mdc_en (state != StGap),
        .mdc    (phy_mdc),
        .fall   (fall),
        .rise   (rise),
        .bit_end(bit_end)
    );

    // Frame sequencer: pin shifters, read capture, response and bit/field counting.
    always_ff @(posedge msoc_clk) begin
        if (rst_int) begin
            state        <= StIdle;
            bit_cnt      <= 5'd0;
            is_write     <= 1'b0;
            ta_err       <= 1'b0;
            rd_sr        <= 16'h0000;
            tx_sr        <= '1;
            oe_sr        <= '0;
            phy_mdio_o   <= 1'b1;
            phy_mdio_oen <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            // Pins change only as MDC falls; idle level (1, released) shifts in behind the frame.
            if (accept) begin
                phy_mdio_o   <= frame_tx[FB-1];
                phy_mdio_oen <= frame_en[FB-1];
                tx_sr        <= {frame_tx[FB-2:0], 1'b1};
                oe_sr        <= {frame_en[FB-2:0], 1'b0};
            end else if (fall) begin
                phy_mdio_o   <= tx_sr[FB-1];
                phy_mdio_oen <= oe_sr[FB-1];
                tx_sr        <= {tx_sr[FB-2:0], 1'b1};
                oe_sr        <= {oe_sr[FB-2:0], 1'b0};
            end

            // PHY data is sampled on the MDC rising edge.
            if (rise) begin
                if ((state == StTa) && (bit_cnt == 5'd1)) begin
                    ta_err <= phy_mdio_i;
                end
                if (state == StData) begin
                    rd_sr <= {rd_sr[14:0], phy_mdio_i};
                end
            end

            // Response lands in the last cycle of GAP so IDLE follows immediately.
            if ((state == StGap) && bit_end) begin
                rsp_valid <= 1'b1;
                if (is_write) begin
                    rsp_err <= 1'b0;
                end else begin
                    rsp_rdata <= rd_sr;
                    rsp_err   <= ta_err;
                end
            end

            case (state)
                StIdle: begin
                    if (accept) begin
                        state    <= (PREAMBLE_EN != 0) ? StPre : StStop;
                        bit_cnt  <= 5'd0;
                        is_write <= req_write;
                    end
                end
                default: begin
                    if (fall) begin
                        if (bit_cnt == state_last_bit(state)) begin
                            bit_cnt <= 5'd0;
                            state   <= state_next(state);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
